// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Result encoding, ordered {lt, eq, gt}.
  localparam logic [2:0] CMP_LT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_GT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  // Counter must hold NDIG itself, hence NDIG+1 states.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
    int unsigned ndig;
    ndig = (digit == 0) ? width : width / digit;
    return (ndig < 1) ? 1 : $clog2(ndig + 1);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit digit pair.
module digit_compare #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o
);

  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Handshaked digit-serial magnitude comparator, MSD first, DIGIT bits per clock.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first unequal digit.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             less_than,
  output logic             equal_to,
  output logic             greater_than,
  output logic             busy
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(WIDTH, DIGIT);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_magnitude_comparator: need WIDTH >= 2, 1 <= DIGIT <= WIDTH, WIDTH %% DIGIT == 0");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             dec_gt_q, dec_gt_d;
  logic [2:0]       flags_q, flags_d;
  logic             out_valid_q, in_ready_q, busy_q;

  logic             dig_lt, dig_eq, dig_gt;
  logic             last_c, exit_c;

  digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
    .a_i  (a_q[WIDTH-1 -: DIGIT]),
    .b_i  (b_q[WIDTH-1 -: DIGIT]),
    .lt_o (dig_lt),
    .eq_o (dig_eq),
    .gt_o (dig_gt)
  );

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    dec_d    = dec_q;
    dec_gt_d = dec_gt_q;
    flags_d  = flags_q;
    last_c   = 1'b0;
    exit_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Flipping the sign bit maps two's complement onto offset binary.
          a_d      = a_in ^ {signed_mode, (WIDTH-1)'(0)};
          b_d      = b_in ^ {signed_mode, (WIDTH-1)'(0)};
          cnt_d    = CW'(NDIG);
          dec_d    = 1'b0;
          dec_gt_d = 1'b0;
          state_d  = COMPARE;
        end
      end

      COMPARE: begin
        a_d    = a_q << DIGIT;
        b_d    = b_q << DIGIT;
        cnt_d  = cnt_q - CW'(1);
        last_c = (cnt_q == CW'(1));
        if (!dec_q && !dig_eq) begin
          dec_d    = 1'b1;
          dec_gt_d = dig_gt;
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        exit_c = last_c || !dig_eq;
`else
        exit_c = last_c;
`endif
        if (exit_c) begin
          state_d = DONE;
          if (dec_q)       flags_d = dec_gt_q ? CMP_GT : CMP_LT;
          else if (dig_eq) flags_d = CMP_EQ;
          else             flags_d = dig_lt ? CMP_LT : CMP_GT;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      dec_gt_q    <= 1'b0;
      flags_q     <= CMP_NONE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      dec_gt_q    <= dec_gt_d;
      flags_q     <= flags_d;
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign less_than    = flags_q[2];
  assign equal_to     = flags_q[1];
  assign greater_than = flags_q[0];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomised self-checking bench for serial_magnitude_comparator (WIDTH=8, DIGIT=2 and DIGIT=1).
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid2, in_valid1;
  logic [7:0] a_in, b_in;
  logic       signed_mode;
  logic       out_ready;

  logic in_ready2, out_valid2, lt2, eq2, gt2, busy2;
  logic in_ready1, out_valid1, lt1, eq1, gt1, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a_in(a_in), .b_in(b_in), .signed_mode(signed_mode),
    .out_valid(out_valid2), .out_ready(out_ready),
    .less_than(lt2), .equal_to(eq2), .greater_than(gt2), .busy(busy2)
  );

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a_in), .b_in(b_in), .signed_mode(signed_mode),
    .out_valid(out_valid1), .out_ready(out_ready),
    .less_than(lt1), .equal_to(eq1), .greater_than(gt1), .busy(busy1)
  );

  // Reference: numeric value of an operand under the selected interpretation.
  function automatic int num_val(input logic [7:0] x, input logic sm);
    return sm ? int'($signed(x)) : int'({1'b0, x});
  endfunction

  function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int ia, ib;
    ia = num_val(a, sm);
    ib = num_val(b, sm);
    if (ia < ib)       return 3'b100;
    else if (ia == ib) return 3'b010;
    else               return 3'b001;
  endfunction

  // Reference latency in edges after capture; early exit stops at the first differing digit.
  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b, input logic sm, input int digit);
    int ndig, ua, ub, da, db, base;
    ndig = 8 / digit;
    ua = num_val(a, sm) + (sm ? 128 : 0);
    ub = num_val(b, sm) + (sm ? 128 : 0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    base = 1 << digit;
    for (int i = 0; i < ndig; i++) begin
      da = (ua / (1 << (8 - (i + 1) * digit))) % base;
      db = (ub / (1 << (8 - (i + 1) * digit))) % base;
      if (da != db) return i + 1;
    end
`else
    base = ua + ub;
`endif
    return ndig;
  endfunction

  function automatic logic get_rdy(input int sel);
    return (sel == 2) ? in_ready2 : in_ready1;
  endfunction

  function automatic logic get_vld(input int sel);
    return (sel == 2) ? out_valid2 : out_valid1;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 2) ? busy2 : busy1;
  endfunction

  function automatic logic [2:0] get_flags(input int sel);
    return (sel == 2) ? {lt2, eq2, gt2} : {lt1, eq1, gt1};
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel == 2) in_valid2 = v;
    else          in_valid1 = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: capture, wait for result, check, handshake.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input string name);
    int n, el;
    logic [2:0] ef;
    a_in = a; b_in = b; signed_mode = sm; out_ready = 1'b0;
    n_cmp++;
    if (get_rdy(sel) !== 1'b1) begin
      n_bad++; $display("FAIL %s idle: in_ready=%b expected 1", name, get_rdy(sel));
    end
    set_valid(sel, 1'b1);
    tick();
    set_valid(sel, 1'b0);
    n_cmp++;
    if (get_busy(sel) !== 1'b1 || get_rdy(sel) !== 1'b0) begin
      n_bad++; $display("FAIL %s busy: busy=%b in_ready=%b expected 1/0", name, get_busy(sel), get_rdy(sel));
    end
    n = 0;
    while (get_vld(sel) !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    el = ref_lat(a, b, sm, (sel == 2) ? 2 : 1);
    ef = ref_flags(a, b, sm);
    n_cmp++;
    if (n !== el) begin
      n_bad++; $display("FAIL %s latency: got %0d expected %0d", name, n, el);
    end
    n_cmp++;
    if (get_flags(sel) !== ef) begin
      n_bad++; $display("FAIL %s flags: got %b expected %b", name, get_flags(sel), ef);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (get_vld(sel) !== 1'b0 || get_rdy(sel) !== 1'b1) begin
      n_bad++; $display("FAIL %s handshake: out_valid=%b in_ready=%b expected 0/1", name, get_vld(sel), get_rdy(sel));
    end
  endtask

  task automatic check_idle_clear(input int sel, input string name);
    n_cmp++;
    if (get_rdy(sel) !== 1'b1 || get_busy(sel) !== 1'b0 || get_vld(sel) !== 1'b0 || get_flags(sel) !== 3'b000) begin
      n_bad++;
      $display("FAIL %s: in_ready=%b busy=%b out_valid=%b flags=%b expected 1/0/0/000",
               name, get_rdy(sel), get_busy(sel), get_vld(sel), get_flags(sel));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid2 = 1'b0; in_valid1 = 1'b0;
    a_in = 8'h00; b_in = 8'h00; signed_mode = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_idle_clear(2, "reset_d2");
    check_idle_clear(1, "reset_d1");
    reset = 1'b0;
    tick();
  endtask

  task automatic test_equal();
    run_op(2, 8'hA5, 8'hA5, 1'b0, "equal_a5");
    run_op(1, 8'h3C, 8'h3C, 1'b1, "equal_d1_signed");
  endtask

  task automatic test_msd_decides();
    run_op(2, 8'h80, 8'h7F, 1'b0, "msd_gt");
    run_op(2, 8'h7F, 8'h80, 1'b0, "msd_lt");
    run_op(2, 8'hFE, 8'hFF, 1'b0, "lsd_lt");
  endtask

  task automatic test_signed();
    run_op(1, 8'h80, 8'h01, 1'b1, "signed_lt");
    run_op(1, 8'h80, 8'h01, 1'b0, "unsigned_gt");
    run_op(2, 8'hFF, 8'h00, 1'b1, "signed_neg1_lt_0");
    run_op(2, 8'h7F, 8'h80, 1'b1, "signed_max_gt_min");
  endtask

  task automatic test_random_single();
    for (int i = 0; i < 8; i++) begin
      run_op((i % 2 == 0) ? 2 : 1, 8'($urandom), 8'($urandom), 1'($urandom), "random_single");
    end
  endtask

  task automatic test_backpressure();
    int n, el;
    a_in = 8'h03; b_in = 8'h05; signed_mode = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b1;
    tick();
    a_in = 8'hF0; b_in = 8'h0F;
    n = 0;
    while (out_valid2 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    el = ref_lat(8'h03, 8'h05, 1'b0, 2);
    n_cmp++;
    if (n !== el) begin
      n_bad++; $display("FAIL bp_latency: got %0d expected %0d", n, el);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (out_valid2 !== 1'b1 || {lt2, eq2, gt2} !== 3'b100 || in_ready2 !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b flags=%b in_ready=%b expected 1/100/0",
                 k, out_valid2, {lt2, eq2, gt2}, in_ready2);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready2, out_valid2);
    end
    tick();
    in_valid2 = 1'b0;
    n_cmp++;
    if (busy2 !== 1'b1) begin
      n_bad++; $display("FAIL bp_recapture: busy=%b expected 1", busy2);
    end
    n = 0;
    while (out_valid2 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if ({lt2, eq2, gt2} !== ref_flags(8'hF0, 8'h0F, 1'b0) || n !== ref_lat(8'hF0, 8'h0F, 1'b0, 2)) begin
      n_bad++;
      $display("FAIL bp_second_result: flags=%b lat=%0d expected %b lat=%0d",
               {lt2, eq2, gt2}, n, ref_flags(8'hF0, 8'h0F, 1'b0), ref_lat(8'hF0, 8'h0F, 1'b0, 2));
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    a_in = 8'h10; b_in = 8'h20; signed_mode = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_clear(2, "mid_reset");
    tick();
    check_idle_clear(2, "mid_reset_no_result");
    run_op(2, 8'h20, 8'h10, 1'b0, "after_reset_gt");
  endtask

  task automatic test_back_to_back();
    logic [2:0] q[$];
    logic [2:0] ef;
    int caps, res, cyc, last_cap, exp_gap;
    logic cap;
    a_in = 8'($urandom); b_in = 8'($urandom); signed_mode = 1'($urandom);
    out_ready = 1'b1;
    in_valid1 = 1'b1;
    caps = 0; res = 0; cyc = 0; last_cap = -1; exp_gap = 0;
    while (res < 100 && cyc < 3000) begin
      cap = in_valid1 && in_ready1;
      if (cap) begin
        if (last_cap >= 0) begin
          n_cmp++;
          if (cyc - last_cap !== exp_gap) begin
            n_bad++; $display("FAIL b2b_spacing: gap %0d expected %0d", cyc - last_cap, exp_gap);
          end
        end
        q.push_back(ref_flags(a_in, b_in, signed_mode));
        exp_gap = ref_lat(a_in, b_in, signed_mode, 1) + 2;
        last_cap = cyc;
        caps++;
      end
      if (out_valid1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL b2b_spurious: flags=%b with no pending operation", {lt1, eq1, gt1});
        end else begin
          ef = q.pop_front();
          if ({lt1, eq1, gt1} !== ef) begin
            n_bad++; $display("FAIL b2b_flags result %0d: got %b expected %b", res, {lt1, eq1, gt1}, ef);
          end
        end
        res++;
      end
      tick();
      cyc++;
      if (cap) begin
        a_in = 8'($urandom); b_in = 8'($urandom); signed_mode = 1'($urandom);
        if (caps == 100) in_valid1 = 1'b0;
      end
    end
    in_valid1 = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (res !== 100) begin
      n_bad++; $display("FAIL b2b_count: got %0d results expected 100", res);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_msd_decides();
    test_signed();
    test_random_single();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
